input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage that feeds the lab flip-flop blocks.
- Takes raw board inputs (push-buttons and slide switches) and delivers clean signals: a clock-pulse button, J, K, preset_ and clear_ switches.
- Per channel: 2-flop synchroniser, counter-based debounce, registered rise/fall strobes.
- Downstream negedge flip-flops consume the debounced levels; the edge strobes are used as single-step enables.

Parameters:
- CHANNELS, 5, number of independent input channels.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a level change is accepted (1 ms at 50 MHz); legal range >= 1.
- IDLE_LEVEL, {CHANNELS{1'b0}}, per-channel reset value of synchroniser and debounced level.
- STRETCH_CYCLES, 4, strobe width when PULSE_STRETCH_EN is defined; legal range >= 1.

Ports:
- clockpulse  in  1  system clock; all state on rising edge.
- clear_  in  1  synchronous active-low reset, sampled on the clockpulse rising edge.
- raw_in  in  CHANNELS  asynchronous raw board inputs.
- level_out  out  CHANNELS  debounced level per channel.
- rise_pulse  out  CHANNELS  strobe on debounced 0->1.
- fall_pulse  out  CHANNELS  strobe on debounced 1->0.

Behaviour:
- Reset (clear_=0 at a rising edge):
  - sync1, sync2 and level_out load IDLE_LEVEL.
  - Counters load 0; rise_pulse and fall_pulse load 0; FSM goes to STABLE.
  - Any count in progress is discarded.
- Synchroniser: sync1<=raw_in, sync2<=sync1. Only sync2 is used downstream.
- Per-channel FSM, STABLE:
  - If sync2==level_out: counter held at 0.
  - Else: counter<=1 and go to CONFIRM.
  - When DEBOUNCE_CYCLES==1: level_out<=sync2 immediately and the FSM stays in STABLE.
- Per-channel FSM, CONFIRM:
  - If sync2==level_out (glitch): counter<=0, go to STABLE, no output change.
  - Else if counter==DEBOUNCE_CYCLES-1: level_out<=sync2, counter<=0, go to STABLE, and fire the matching strobe in the same edge.
  - Else: counter<=counter+1.
- Counter: width max(1,$clog2(DEBOUNCE_CYCLES)). Never wraps, because it clears at the terminal count.
- Latency: a raw change held stable reaches level_out exactly 2+DEBOUNCE_CYCLES rising edges after first being sampled.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES cycles at sync2 produces no level change and no strobe.
- Strobes: rise_pulse[i]/fall_pulse[i] are high for exactly the first cycle in which level_out[i] shows the new value, otherwise 0. Never both high at once.
- Channels are fully independent; simultaneous changes on several channels resolve in parallel with identical timing.

Optional Feature:
- Macro: PULSE_STRETCH_EN.
- Defined:
  - Each strobe stays high for STRETCH_CYCLES cycles, driven by a per-channel stretch counter reset to 0.
  - An opposite-direction event during a stretch ends the current strobe and starts the new one.
  - A same-direction event cannot occur during a stretch.
- Undefined: strobes are exactly one cycle wide and no stretch counters exist.

Decomposition:
- Shared package input_conditioner_pkg:
  - state typedef {STABLE, CONFIRM};
  - default constants DEBOUNCE_1MS_50MHZ=50000 and DEFAULT_STRETCH=4.
- Sub-module debounce_channel: one synchroniser, FSM, counter and strobe logic, parameterised by DEBOUNCE_CYCLES, IDLE_BIT and STRETCH_CYCLES.
- Top level is a generate loop over CHANNELS.

Test Plan (DEBOUNCE_CYCLES=4, CHANNELS=5, IDLE_LEVEL=0):
- Reset: hold clear_=0 for 3 cycles with raw_in=5'b11111 -> level_out=0, both strobes 0 throughout.
- Clean press: raw_in[0] 0->1 held -> level_out[0]=1 on the 6th edge after first sample; rise_pulse[0]=1 for exactly that cycle.
- Glitch: raw_in[1]=1 for 3 cycles then 0 -> level_out[1] stays 0, no strobes.
- Release and reset mid-count:
  - Release raw_in[0] -> fall_pulse[0] one cycle, 6 edges after the change.
  - Repeat the release but assert clear_ at the 3rd count -> level_out=0, counter restarts after reset.
- Parallel channels: raw_in 5'b00000->5'b10101 simultaneously -> level_out=5'b10101 on the same edge; rise_pulse=5'b10101 for one cycle.
- With PULSE_STRETCH_EN: clean press -> rise_pulse[0] high for 4 consecutive cycles, then 0.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// ============================================================================
// Module      : input_conditioner_pkg
// Description : Shared types and default constants for the input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_conditioner_pkg;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } state_e;

  localparam int DEBOUNCE_1MS_50MHZ = 50000;
  localparam int DEFAULT_STRETCH    = 4;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : One input channel: 2-flop synchroniser, counter debounce and
//               registered rise/fall strobes. PULSE_STRETCH_EN widens strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter logic IDLE_BIT        = 1'b0,
  parameter int   STRETCH_CYCLES  = DEFAULT_STRETCH
) (
  input  logic clockpulse,
  input  logic clear_,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_param_check
    $error("debounce_channel: DEBOUNCE_CYCLES and STRETCH_CYCLES must be >= 1");
  end

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q, level_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic             rise_evt;
  logic             fall_evt;

  always_comb begin
    level_d  = level_q;
    state_d  = state_q;
    count_d  = count_q;
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    case (state_q)
      STABLE: begin
        count_d = '0;
        if (sync2_q != level_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            level_d  = sync2_q;
            rise_evt = sync2_q;
            fall_evt = ~sync2_q;
          end else begin
            count_d = CNT_W'(1);
            state_d = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (sync2_q == level_q) begin
          count_d = '0;
          state_d = STABLE;
        end else if (count_q == TERM_CNT) begin
          level_d  = sync2_q;
          count_d  = '0;
          state_d  = STABLE;
          rise_evt = sync2_q;
          fall_evt = ~sync2_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        count_d = '0;
        state_d = STABLE;
      end
    endcase
  end

`ifdef PULSE_STRETCH_EN
  localparam int               STR_W    = cnt_width(STRETCH_CYCLES);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_CYCLES - 1);

  logic [STR_W-1:0] stretch_q, stretch_d;

  // A new event always restarts the stretch, so an opposite edge cuts the old strobe short.
  always_comb begin
    rise_d    = rise_q;
    fall_d    = fall_q;
    stretch_d = stretch_q;
    if (rise_evt || fall_evt) begin
      rise_d    = rise_evt;
      fall_d    = fall_evt;
      stretch_d = STR_LOAD;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - 1'b1;
    end else begin
      rise_d = 1'b0;
      fall_d = 1'b0;
    end
  end

  always_ff @(posedge clockpulse) begin
    if (!clear_) begin
      stretch_q <= '0;
    end else begin
      stretch_q <= stretch_d;
    end
  end
`else
  always_comb begin
    rise_d = rise_evt;
    fall_d = fall_evt;
  end
`endif

  always_ff @(posedge clockpulse) begin
    if (!clear_) begin
      sync1_q <= IDLE_BIT;
      sync2_q <= IDLE_BIT;
      level_q <= IDLE_BIT;
      state_q <= STABLE;
      count_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      state_q <= state_d;
      count_q <= count_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module      : input_conditioner
// Description : Debounces CHANNELS raw board inputs into clean levels and
//               edge strobes. Optional macro PULSE_STRETCH_EN widens strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                  CHANNELS        = 5,
  parameter int                  DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter logic [CHANNELS-1:0] IDLE_LEVEL      = '0,
  parameter int                  STRETCH_CYCLES  = DEFAULT_STRETCH
) (
  input  logic                clockpulse,
  input  logic                clear_,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_BIT        (IDLE_LEVEL[g]),
      .STRETCH_CYCLES  (STRETCH_CYCLES)
    ) u_channel (
      .clockpulse (clockpulse),
      .clear_     (clear_),
      .raw_in     (raw_in[g]),
      .level_out  (level_out[g]),
      .rise_pulse (rise_pulse[g]),
      .fall_pulse (fall_pulse[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================================
// Module      : tb_input_conditioner
// Description : Directed self-checking bench for input_conditioner with
//               DEBOUNCE_CYCLES=4; honours PULSE_STRETCH_EN for strobe width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int CH = 5;
  localparam int DB = 4;
  localparam int ST = DEFAULT_STRETCH;
`ifdef PULSE_STRETCH_EN
  localparam int SW = ST;
`else
  localparam int SW = 1;
`endif

  logic          clockpulse = 1'b0;
  logic          clear_     = 1'b0;
  logic [CH-1:0] raw_in     = '0;
  logic [CH-1:0] level_out;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clockpulse = ~clockpulse;

  input_conditioner #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (DB),
    .IDLE_LEVEL      ('0),
    .STRETCH_CYCLES  (ST)
  ) dut (
    .clockpulse (clockpulse),
    .clear_     (clear_),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockpulse);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [CH-1:0] lvl,
                           input logic [CH-1:0] rise, input logic [CH-1:0] fall);
    check_val({tag, "_level"}, level_out, lvl);
    check_val({tag, "_rise"}, rise_pulse, rise);
    check_val({tag, "_fall"}, fall_pulse, fall);
  endtask

  task automatic idle(input int n, input logic [CH-1:0] lvl, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all(tag, lvl, '0, '0);
    end
  endtask

  // Drive raw_in, expect the old level for DB+1 edges, the new one on edge DB+2
  // with strobes held SW cycles, then strobes back to zero.
  task automatic change(input string tag, input logic [CH-1:0] new_raw,
                        input logic [CH-1:0] old_lvl, input logic [CH-1:0] new_lvl,
                        input logic [CH-1:0] rmask, input logic [CH-1:0] fmask);
    raw_in = new_raw;
    idle(DB + 1, old_lvl, {tag, "_wait"});
    for (int i = 0; i < SW; i++) begin
      tick();
      check_all({tag, "_edge"}, new_lvl, rmask, fmask);
    end
    tick();
    check_all({tag, "_after"}, new_lvl, '0, '0);
  endtask

  initial begin
    clear_ = 1'b0;
    raw_in = 5'b11111;
    idle(3, 5'b00000, "reset");

    clear_ = 1'b1;
    raw_in = 5'b00000;
    idle(4, 5'b00000, "post_reset");

    change("press0", 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000);

    raw_in = 5'b00011;
    idle(3, 5'b00001, "glitch_hi");
    raw_in = 5'b00001;
    idle(8, 5'b00001, "glitch_lo");

    change("release0", 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00001);

    change("press0b", 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000);
    raw_in = 5'b00000;
    idle(4, 5'b00001, "rel_pre_rst");
    clear_ = 1'b0;
    idle(1, 5'b00000, "rel_rst");
    clear_ = 1'b1;
    idle(8, 5'b00000, "rel_post_rst");

    // Reset mid-count with the input still changed: full latency must apply again.
    raw_in = 5'b00001;
    idle(4, 5'b00000, "prs_pre_rst");
    clear_ = 1'b0;
    idle(1, 5'b00000, "prs_rst");
    clear_ = 1'b1;
    change("prs_restart", 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000);

    clear_ = 1'b0;
    raw_in = 5'b00000;
    idle(2, 5'b00000, "par_rst");
    clear_ = 1'b1;
    change("parallel", 5'b10101, 5'b00000, 5'b10101, 5'b10101, 5'b00000);
    change("par_release", 5'b00000, 5'b10101, 5'b00000, 5'b00000, 5'b10101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
